// File: rtl/imm_gen_pipe.sv
// Immediate generator: decodes MIPS opcodes into imm/target/kind, buffered in a FIFO.
// Latency: 1 cycle from an accepted instruction to the FIFO head; 1 entry per cycle.
// Backpressure: in_ready falls when the FIFO is full; the head is held while out_ready is low.

// Generic synchronous FIFO. Storage is cleared by reset and kept by flush.
// Latency: 1 cycle push-to-head; one push and one pop per cycle.
// Backpressure: push_rdy follows the occupancy only; a same-cycle pop does not free a full FIFO.
module imm_gen_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop;

    assign push_rdy = (cnt_q != CW'(DEPTH));
    assign pop_vld  = (cnt_q != '0);
    // The head is read straight from storage, so it holds the last contents when empty.
    assign pop_dat  = mem_q[rd_ptr_q];
    assign push     = push_vld & push_rdy;
    assign pop      = pop_vld & pop_rdy;

    // Next-state: flush discards any same-cycle push/pop and rewinds the pointers.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    // State registers; reset also clears storage so the head reads zero afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

module imm_gen_pipe #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int SHAMT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_pc_plus4,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_target,
    output logic [2:0]        out_kind,
    output logic              out_illegal
);
    localparam logic [2:0] K_NONE   = 3'd0;
    localparam logic [2:0] K_SEXT   = 3'd1;
    localparam logic [2:0] K_ZEXT   = 3'd2;
    localparam logic [2:0] K_UPPER  = 3'd3;
    localparam logic [2:0] K_BRANCH = 3'd4;
    localparam logic [2:0] K_JUMP   = 3'd5;

    // Upper PC bits kept by a jump; everything below is index plus alignment zeros.
    localparam logic [DATA_W-1:0] JMP_HI_MASK = {DATA_W{1'b1}} << (26 + SHAMT);

    typedef struct packed {
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] target;
        logic [2:0]        kind;
        logic              illegal;
    } ent_t;

    localparam int ENT_W = $bits(ent_t);

    ent_t        dec_dat;
    ent_t        head_dat;
    logic [5:0]  opcode;
    logic [15:0] imm16;
    logic [31:0] upper32;
    logic [DATA_W-1:0] sext_imm;

    assign opcode   = in_instr[31:26];
    assign imm16    = in_instr[15:0];
    assign upper32  = {imm16, 16'h0000};
    assign sext_imm = DATA_W'($signed(imm16));

    // Opcode decode into the FIFO entry; target stays zero except for branches and jumps.
    always_comb begin
        dec_dat = '0;
        unique case (opcode)
            6'b100011, 6'b101011, 6'b001000,
            6'b001001, 6'b001010, 6'b001011: begin
                dec_dat.kind = K_SEXT;
                dec_dat.imm  = sext_imm;
            end
            6'b001100, 6'b001101, 6'b001110: begin
                dec_dat.kind = K_ZEXT;
                dec_dat.imm  = DATA_W'(imm16);
            end
            6'b001111: begin
                dec_dat.kind = K_UPPER;
                dec_dat.imm  = DATA_W'($signed(upper32));
            end
            6'b000100, 6'b000101: begin
                dec_dat.kind   = K_BRANCH;
                dec_dat.imm    = sext_imm;
                dec_dat.target = in_pc_plus4 + (sext_imm << SHAMT);
            end
            6'b000010, 6'b000011: begin
                dec_dat.kind   = K_JUMP;
                dec_dat.imm    = DATA_W'(in_instr[25:0]);
                dec_dat.target = (in_pc_plus4 & JMP_HI_MASK)
                               | (DATA_W'(in_instr[25:0]) << SHAMT);
            end
            6'b000000: begin
                dec_dat.kind = K_NONE;
            end
            default: begin
                dec_dat.kind    = K_NONE;
                dec_dat.illegal = 1'b1;
            end
        endcase
    end

    imm_gen_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat (dec_dat),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (head_dat)
    );

    assign out_imm     = head_dat.imm;
    assign out_target  = head_dat.target;
    assign out_kind    = head_dat.kind;
    assign out_illegal = head_dat.illegal;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode kinds, targets, backpressure, flush, reset, 64-bit build.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that point too.
// Two instances: the default 32-bit build and a 64-bit build for wide-extension checks.
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc_plus4;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [31:0] out_target;
    logic [2:0]  out_kind;
    logic        out_illegal;

    logic        in_valid64;
    logic        in_ready64;
    logic [31:0] in_instr64;
    logic [63:0] in_pc_plus4_64;
    logic        out_valid64;
    logic        out_ready64;
    logic [63:0] out_imm64;
    logic [63:0] out_target64;
    logic [2:0]  out_kind64;
    logic        out_illegal64;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imm_gen_pipe u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc_plus4 (in_pc_plus4),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_target  (out_target),
        .out_kind    (out_kind),
        .out_illegal (out_illegal)
    );

    imm_gen_pipe #(.DATA_W(64), .DEPTH(2), .SHAMT(2)) u_dut64 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (1'b0),
        .in_valid    (in_valid64),
        .in_ready    (in_ready64),
        .in_instr    (in_instr64),
        .in_pc_plus4 (in_pc_plus4_64),
        .out_valid   (out_valid64),
        .out_ready   (out_ready64),
        .out_imm     (out_imm64),
        .out_target  (out_target64),
        .out_kind    (out_kind64),
        .out_illegal (out_illegal64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    task automatic push1(input logic [31:0] instr, input logic [31:0] pc);
        in_instr    = instr;
        in_pc_plus4 = pc;
        in_valid    = 1'b1;
        tick();
        in_valid    = 1'b0;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] imm, input logic [31:0] tgt,
                            input logic [2:0] kind, input logic ill);
        chk({tag, ".vld"},  64'(out_valid),   64'd1);
        chk({tag, ".imm"},  64'(out_imm),     64'(imm));
        chk({tag, ".tgt"},  64'(out_target),  64'(tgt));
        chk({tag, ".kind"}, 64'(out_kind),    64'(kind));
        chk({tag, ".ill"},  64'(out_illegal), 64'(ill));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held 2 cycles with an instruction offered.
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_instr = itype(6'b001000, 16'h1234); in_pc_plus4 = 32'h0;
        in_valid64 = 1'b0; out_ready64 = 1'b1; in_instr64 = 32'h0; in_pc_plus4_64 = 64'h0;
        tick();
        tick();
        chk("rst.vld",  64'(out_valid),   64'd0);
        chk("rst.imm",  64'(out_imm),     64'd0);
        chk("rst.tgt",  64'(out_target),  64'd0);
        chk("rst.kind", 64'(out_kind),    64'd0);
        chk("rst.ill",  64'(out_illegal), 64'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        chk("rst.rdy_after", 64'(in_ready),  64'd1);
        chk("rst.vld_after", 64'(out_valid), 64'd0);

        // Decode kinds, downstream always ready: each new push replaces the head.
        out_ready = 1'b1;
        push1(itype(6'b001000, 16'hFFF0), 32'h0);
        chk_head("addi", 32'hFFFF_FFF0, 32'h0, 3'd1, 1'b0);
        push1(itype(6'b001101, 16'h8001), 32'h0);
        chk_head("ori", 32'h0000_8001, 32'h0, 3'd2, 1'b0);
        push1(itype(6'b001111, 16'h1234), 32'h0);
        chk_head("lui", 32'h1234_0000, 32'h0, 3'd3, 1'b0);
        push1(itype(6'b111111, 16'hABCD), 32'h0);
        chk_head("illop", 32'h0, 32'h0, 3'd0, 1'b1);
        push1(itype(6'b000100, 16'hFFFF), 32'h0040_0010);
        chk_head("beq", 32'hFFFF_FFFF, 32'h0040_000C, 3'd4, 1'b0);
        push1(itype(6'b000101, 16'h0003), 32'h0000_1000);
        chk_head("bne", 32'h0000_0003, 32'h0000_100C, 3'd4, 1'b0);
        push1({6'b000010, 26'h000_0100}, 32'h1000_0004);
        chk_head("j", 32'h0000_0100, 32'h1000_0400, 3'd5, 1'b0);
        push1({6'b000011, 26'h3FF_FFFF}, 32'hA000_0000);
        chk_head("jal", 32'h03FF_FFFF, 32'hAFFF_FFFC, 3'd5, 1'b0);
        push1(itype(6'b100011, 16'h8000), 32'h0);
        chk_head("lw", 32'hFFFF_8000, 32'h0, 3'd1, 1'b0);
        push1(itype(6'b001110, 16'hFFFF), 32'h0);
        chk_head("xori", 32'h0000_FFFF, 32'h0, 3'd2, 1'b0);
        push1(32'h0123_4020, 32'h0000_0040);
        chk_head("rtype", 32'h0, 32'h0, 3'd0, 1'b0);
        tick();
        chk("drain.vld", 64'(out_valid), 64'd0);

        // Backpressure: three back-to-back pushes into a 2-entry FIFO.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = itype(6'b001001, 16'h0001);
        tick();
        chk("bp.rdy1", 64'(in_ready), 64'd1);
        in_instr = itype(6'b001001, 16'h0002);
        tick();
        chk("bp.rdy2", 64'(in_ready), 64'd0);
        in_instr = itype(6'b001001, 16'h0003);
        tick();
        chk("bp.rdy3", 64'(in_ready), 64'd0);
        chk("bp.stall_head", 64'(out_imm), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("bp.pop1_vld", 64'(out_valid), 64'd1);
        chk("bp.pop1_imm", 64'(out_imm),   64'd2);
        chk("bp.pop1_rdy", 64'(in_ready),  64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp.pop2_vld", 64'(out_valid), 64'd1);
        chk("bp.pop2_imm", 64'(out_imm),   64'd3);
        tick();
        chk("bp.empty", 64'(out_valid), 64'd0);

        // Sustained push+pop at count 1, wrapping the pointers several times.
        push1(itype(6'b001101, 16'h0100), 32'h0);
        for (int i = 1; i <= 8; i++) begin
            in_instr = itype(6'b001101, 16'h0100 + 16'(i));
            in_valid = 1'b1;
            tick();
            chk($sformatf("pp%0d.vld", i), 64'(out_valid), 64'd1);
            chk($sformatf("pp%0d.rdy", i), 64'(in_ready),  64'd1);
            chk($sformatf("pp%0d.imm", i), 64'(out_imm),   64'(32'h0100 + i));
        end
        in_valid = 1'b0;
        tick();
        chk("pp.empty", 64'(out_valid), 64'd0);

        // Flush with two entries stored and in_valid asserted.
        out_ready = 1'b0;
        push1(itype(6'b001000, 16'h0011), 32'h0);
        push1(itype(6'b001000, 16'h0022), 32'h0);
        flush = 1'b1; in_valid = 1'b1; in_instr = itype(6'b001000, 16'h0033);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl2.vld", 64'(out_valid), 64'd0);
        chk("fl2.rdy", 64'(in_ready),  64'd1);
        tick();
        chk("fl2.still_empty", 64'(out_valid), 64'd0);

        // Flush with one entry while a push would be accepted: push is discarded.
        push1(itype(6'b001000, 16'h0044), 32'h0);
        flush = 1'b1; in_valid = 1'b1; in_instr = itype(6'b001000, 16'h0055);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl1.vld", 64'(out_valid), 64'd0);
        tick();
        chk("fl1.still_empty", 64'(out_valid), 64'd0);

        // Reset mid-stream clears storage as well as occupancy.
        push1(itype(6'b001111, 16'h5A5A), 32'h0);
        chk("mid.vld_before", 64'(out_valid), 64'd1);
        rst_n = 1'b0; in_valid = 1'b1; flush = 1'b1;
        tick();
        rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0;
        chk("mid.vld",  64'(out_valid), 64'd0);
        chk("mid.imm",  64'(out_imm),   64'd0);
        chk("mid.kind", 64'(out_kind),  64'd0);
        chk("mid.rdy",  64'(in_ready),  64'd1);

        // 64-bit build.
        in_instr64 = itype(6'b001111, 16'h8000);
        in_valid64 = 1'b1;
        tick();
        chk("w64.lui_imm",  out_imm64,        64'hFFFF_FFFF_8000_0000);
        chk("w64.lui_kind", 64'(out_kind64),  64'd3);
        in_instr64 = itype(6'b000100, 16'hFFFF);
        in_pc_plus4_64 = 64'h0000_0001_0000_0000;
        tick();
        chk("w64.beq_imm", out_imm64,    64'hFFFF_FFFF_FFFF_FFFF);
        chk("w64.beq_tgt", out_target64, 64'h0000_0000_FFFF_FFFC);
        in_instr64 = {6'b000010, 26'h000_0100};
        in_pc_plus4_64 = 64'h0000_0001_2000_0004;
        tick();
        chk("w64.j_tgt", out_target64, 64'h0000_0001_2000_0400);
        chk("w64.j_ill", 64'(out_illegal64), 64'd0);
        in_valid64 = 1'b0;
        tick();
        chk("w64.empty", 64'(out_valid64), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
